// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction fields into 32-bit words and queues
// them in a small output FIFO.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   encode request present
//   in_ready   request can be accepted (FIFO not full)
//   in_type    instruction class: 0=R 1=I-ALU 2=load 3=store 4=branch
//              5=jal 6=jalr 7=lui 8=auipc, 9-15 illegal
//   func3      funct3 field
//   func7      value for instruction bit 30
//   rd/rs1/rs2 register indices
//   imm        sign-extended byte offset or U value
//   out_valid  FIFO head valid
//   out_ready  consumer takes the head
//   out_inst   encoded word at the FIFO head (0 when empty)
//   err        one-cycle pulse after a rejected request
//   count      FIFO occupancy
module inst_encoder #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_type,
   input  logic [2:0]               func3,
   input  logic                     func7,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [31:0]              imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = DEPTH[AW:0];

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;

   logic [31:0]   enc_word;
   logic          illegal;
   logic          accept, push, pop;

   // Field packing; unused fields of each class simply do not appear.
   always_comb begin
      enc_word = 32'd0;
      illegal  = 1'b0;
      case (in_type)
         4'd0: enc_word = {1'b0, func7, 5'b00000, rs2, rs1, func3, rd, OpR};
         4'd1: begin
            if (func3 == 3'b001 || func3 == 3'b101) begin
               enc_word = {1'b0, func7, 5'b00000, imm[4:0], rs1, func3, rd, OpI};
            end else begin
               enc_word = {imm[11:0], rs1, func3, rd, OpI};
            end
         end
         4'd2: enc_word = {imm[11:0], rs1, func3, rd, OpLoad};
         4'd3: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], OpStore};
         4'd4: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OpBranch};
            illegal  = imm[0];
         end
         4'd5: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
            illegal  = imm[0];
         end
         4'd6: enc_word = {imm[11:0], rs1, 3'b000, rd, OpJalr};
         4'd7: enc_word = {imm[31:12], rd, OpLui};
         4'd8: enc_word = {imm[31:12], rd, OpAuipc};
         default: illegal = 1'b1;
      endcase
   end

   assign in_ready  = (count_q < FullCnt);
   assign out_valid = (count_q != '0);
   assign out_inst  = out_valid ? mem_q[rd_ptr_q] : 32'd0;
   assign err       = err_q;
   assign count     = count_q;

   // A pop needs out_valid, so a push into an empty FIFO never bypasses.
   assign accept = in_valid & in_ready;
   assign push   = accept & ~illegal;
   assign pop    = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      err_d    = accept & illegal;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: out_inst is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= enc_word;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_type;
   logic [2:0]    func3;
   logic          func7;
   logic [4:0]    rd, rs1, rs2;
   logic [31:0]   imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_inst;
   logic          err;
   logic [CW-1:0] count;

   int tests = 0;
   int fails = 0;

   inst_encoder #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_type   (in_type),
      .func3     (func3),
      .func7     (func7),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .err       (err),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  typ;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] t, input logic [2:0] f3, input logic f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
      in_type = t;
      func3   = f3;
      func7   = f7;
      rd      = d;
      rs1     = s1;
      rs2     = s2;
      imm     = im;
   endtask

   // Reference encoder built from bit positions with shifts and masks.
   function automatic logic [32:0] ref_enc(input logic [3:0] t, input logic [2:0] f3,
                                           input logic f7, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
      logic [31:0] w;
      logic [31:0] r_d, r_s1, r_s2, r_f3, r_f7;
      logic [6:0]  opc [9];
      logic        legal;
      opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      r_d  = 32'(d) << 7;
      r_s1 = 32'(s1) << 15;
      r_s2 = 32'(s2) << 20;
      r_f3 = 32'(f3) << 12;
      r_f7 = 32'(f7) << 30;
      w = 32'd0;
      legal = (t < 4'd9) && !((t == 4'd4 || t == 4'd5) && ((im & 32'd1) != 0));
      if (t < 4'd9) begin
         w = 32'(opc[t]);
         case (t)
            4'd0: w = w | r_f7 | r_s2 | r_s1 | r_f3 | r_d;
            4'd1: begin
               if (f3 == 3'd1 || f3 == 3'd5) w = w | r_f7 | ((im & 32'h1F) << 20) | r_s1 | r_f3 | r_d;
               else w = w | ((im & 32'hFFF) << 20) | r_s1 | r_f3 | r_d;
            end
            4'd2: w = w | ((im & 32'hFFF) << 20) | r_s1 | r_f3 | r_d;
            4'd3: w = w | (((im >> 5) & 32'h7F) << 25) | r_s2 | r_s1 | r_f3 | ((im & 32'h1F) << 7);
            4'd4: w = w | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r_s2
                      | r_s1 | r_f3 | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            4'd5: w = w | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | r_d;
            4'd6: w = w | ((im & 32'hFFF) << 20) | r_s1 | r_d;
            default: w = w | (im & 32'hFFFFF000) | r_d;
         endcase
      end
      return {legal, w};
   endfunction

   logic [31:0] q [$];
   logic [31:0] exp_word;
   logic [32:0] enc;
   logic        acc, pop_m, err_m;

   initial begin
      vecs[0] = '{4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3};
      vecs[1] = '{4'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'h403100B3};
      vecs[2] = '{4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293};
      vecs[3] = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093};
      vecs[4] = '{4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd1, 32'd8, 32'h00112423};
      vecs[5] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3};
      vecs[6] = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF};
      vecs[7] = '{4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7};
      vecs[8] = '{4'd2, 3'd2, 1'b0, 5'd3, 5'd4, 5'd0, 32'd16, 32'h01022183};
      vecs[9] = '{4'd6, 3'd7, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4, 32'h004280E7};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      drive(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      step();
      step();
      rst = 1'b0;
      check("reset_count", 32'(count), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_inst", out_inst, 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Directed encodings: push one word, see it one cycle later, pop it.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].typ, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].imm);
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp);
         check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
      end

      // Rejected requests: misaligned branch, then illegal class.
      drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
      in_valid = 1'b1;
      step();
      check("err_branch_pulse", 32'(err), 32'd1);
      check("err_branch_count", 32'(count), 32'd0);
      drive(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd0);
      step();
      in_valid = 1'b0;
      check("err_type12_pulse", 32'(err), 32'd1);
      check("err_type12_count", 32'(count), 32'd0);
      check("err_type12_valid", 32'(out_valid), 32'd0);
      step();
      check("err_pulse_ends", 32'(err), 32'd0);

      // Fill, pop one while full, then drain and confirm order.
      q.delete();
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drive(4'd7, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1) << 12);
         q.push_back(ref_enc(4'd7, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1) << 12));
         step();
      end
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), DEPTH);
      check("full_head", out_inst, q[0]);
      out_ready = 1'b1;
      step();
      void'(q.pop_front());
      out_ready = 1'b0;
      check("full_pop_ready", 32'(in_ready), 32'd1);
      check("full_pop_count", 32'(count), DEPTH - 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         check($sformatf("drain%0d", i), out_inst, q[0]);
         step();
         void'(q.pop_front());
      end
      out_ready = 1'b0;
      check("drain_empty", 32'(count), 32'd0);

      // Reset mid-stream with a request pending in the reset cycle.
      in_valid = 1'b1;
      drive(4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
      step();
      step();
      check("pre_rst_count", 32'(count), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_mid_count", 32'(count), 32'd0);
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_inst", out_inst, 32'd0);
      step();
      check("rst_mid_stays", 32'(count), 32'd0);

      // Randomized traffic against the queue model.
      q.delete();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 5);
         drive(4'($urandom_range(0, 15)), 3'($urandom), 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), $urandom);
         if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
         check("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         enc   = ref_enc(in_type, func3, func7, rd, rs1, rs2, imm);
         acc   = in_valid && (q.size() < DEPTH);
         pop_m = out_ready && (q.size() > 0);
         err_m = acc && !enc[32] && !rst;
         step();
         if (rst) begin
            q.delete();
         end else begin
            if (pop_m) void'(q.pop_front());
            if (acc && enc[32]) q.push_back(enc[31:0]);
         end
         exp_word = (q.size() > 0) ? q[0] : 32'd0;
         check("rnd_count", 32'(count), q.size());
         check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
         check("rnd_out_inst", out_inst, exp_word);
         check("rnd_err", 32'(err), 32'(err_m));
      end
      rst = 1'b0;
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the output FIFO depth in words (a power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port in_type, input, 4 bits: instruction class, encoded 0=R, 1=I-ALU, 2=load, 3=store, 4=branch, 5=jal, 6=jalr, 7=lui, 8=auipc; 9-15 are illegal.
REQ-007 SHALL have port func3, input, 3 bits: funct3 field.
REQ-008 SHALL have port func7, input, 1 bit: value for instruction bit 30 (R-type and I-type shifts).
REQ-009 SHALL have ports rd, rs1 and rs2, each input, 5 bits: register indices.
REQ-010 SHALL have port imm, input, 32 bits: the immediate, sign-extended byte offset or U value.
REQ-011 SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-013 SHALL have port out_inst, output, 32 bits: the encoded RV32I word at the FIFO head.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected request.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 SHALL accept a request on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready=1 exactly when count<DEPTH, independent of out_ready.
REQ-018 SHALL use these opcodes: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
REQ-019 SHALL encode R-type as {0,func7,00000,rs2,rs1,func3,rd,op}.
REQ-020 SHALL encode I-ALU as {imm[11:0],rs1,func3,rd,op}, except shifts.
REQ-021 SHALL encode I-ALU shifts (func3=001 or 101) with bits[31:25]={0,func7,00000} and bits[24:20]=imm[4:0].
REQ-022 SHALL encode load as {imm[11:0],rs1,func3,rd,op}.
REQ-023 SHALL encode jalr as {imm[11:0],rs1,000,rd,op}; func3 is ignored.
REQ-024 SHALL encode store as {imm[11:5],rs2,rs1,func3,imm[4:0],op}.
REQ-025 SHALL encode branch as {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],op}.
REQ-026 SHALL encode jal as {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-027 SHALL encode lui and auipc as {imm[31:12],rd,op}.
REQ-028 SHALL silently ignore all fields unused by the class.
REQ-029 SHALL reject an accepted request if in_type>=9, or if it is branch/jal with imm[0]=1.
REQ-030 SHALL NOT push a rejected request; it still consumes the handshake, and err=1 on the following cycle.
REQ-031 SHALL push a legal accepted request so that it is visible as out_valid/out_inst on the next cycle (1-cycle latency).
REQ-032 SHALL pop the head on a cycle with out_valid=1 and out_ready=1.
REQ-033 SHALL drive out_valid=1 exactly when count>0.
REQ-034 SHALL drive out_inst=0 when the FIFO is empty.
REQ-035 SHALL deliver words in acceptance order; read and write pointers wrap modulo DEPTH.
REQ-036 SHALL apply both operations on a cycle with simultaneous push and pop at count>0, leaving count unchanged.
REQ-037 SHALL, on simultaneous push and pop at count=0, apply only the push (no bypass); count becomes 1.
REQ-038 SHALL, when full, hold in_ready=0; a pop in that cycle raises in_ready on the next cycle.
REQ-039 SHALL keep count in the range 0..DEPTH; no overflow or underflow is possible.

Reset
REQ-040 SHALL, with rst=1 at a clock edge, set count=0, pointers=0, out_valid=0, out_inst=0, err=0 and in_ready=1 after that edge.
REQ-041 SHALL give rst priority over a simultaneous handshake; a request or pop in the reset cycle is lost.
REQ-042 SHALL discard FIFO contents on reset mid-stream; no stale word appears after reset.

Verification
REQ-043 Bench SHALL check: R add (type 0, rd=1, rs1=2, rs2=3, func3=0, func7=0) -> out_inst=0x003100B3 one cycle later; sub (func7=1) -> 0x403100B3.
REQ-044 Bench SHALL check: I srai (type 1, func3=101, func7=1, rd=5, rs1=6, imm=3) -> 0x40335293; addi (func3=0, rd=1, rs1=0, imm=-1) -> 0xFFF00093.
REQ-045 Bench SHALL check: store sw (type 3, func3=010, rs1=2, rs2=1, imm=8) -> 0x00112423; branch beq (rs1=rs2=0, imm=-4) -> 0xFE000EE3; jal (rd=1, imm=8) -> 0x008000EF.
REQ-046 Bench SHALL check: branch with imm=3, then in_type=12 -> err pulse on each, count stays 0, out_valid=0.
REQ-047 Bench SHALL check: with out_ready=0, push DEPTH words -> in_ready=0 and count=DEPTH; assert out_ready for 1 cycle -> the first word pops and in_ready=1 next cycle; then drain all and confirm order.
REQ-048 Bench SHALL check: 2 words queued, rst=1 for one cycle with in_valid=1 -> count=0, out_valid=0 and out_inst=0 afterwards.
